// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx                                                    |
// | Description : 16x oversampling UART receiver (start/8 data/opt. parity/  |
// |               stop) with held output byte and rdy/ack handshake.         |
// |               Optional overrun flag enabled by macro UART_RX_OVERRUN_EN.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter string PARITY   = "ODD",
  parameter int    STOP_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bd_en,
  input  logic       rx,
  input  logic       rx_ack,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_ovr
);

  localparam logic c_par_en   = (PARITY != "NONE");
  localparam logic c_par_odd  = (PARITY == "ODD");
  localparam logic c_two_stop = (STOP_BIT == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_LOAD   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [1:0] r_sync;
  logic       w_rxs;
  logic [3:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic       r_perr_acc;
  logic       r_ferr_acc;
  logic       r_stop_idx;
  logic       r_rdy;
  logic [7:0] r_data;
  logic       r_perr;
  logic       r_ferr;

  logic w_bit_tick;
  logic w_cnt_clr;
  logic w_shift;
  logic w_par_smp;
  logic w_stop_smp;
  logic w_load;

  assign w_rxs      = r_sync[1];
  assign w_bit_tick = rx_bd_en && (r_cnt == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_clr  = 1'b0;
    w_shift    = 1'b0;
    w_par_smp  = 1'b0;
    w_stop_smp = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_bd_en && !w_rxs) begin
          w_state_nx = S_START;
          w_cnt_clr  = 1'b1;
        end
      end
      S_START: begin
        // Seventh tick after detection lands mid start bit
        if (rx_bd_en && (r_cnt == 4'd6)) begin
          w_cnt_clr  = 1'b1;
          w_state_nx = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_tick) begin
          w_shift = 1'b1;
          if (r_bit == 3'd7) begin
            w_state_nx = c_par_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_tick) begin
          w_par_smp  = 1'b1;
          w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_tick) begin
          w_stop_smp = 1'b1;
          if (!c_two_stop || r_stop_idx) begin
            w_state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_load     = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Counter free-runs on ticks and wraps every 16, giving the bit spacing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_bit      <= 3'd0;
      r_shift    <= 8'h00;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt      <= 4'd0;
        r_bit      <= 3'd0;
        r_perr_acc <= 1'b0;
        r_ferr_acc <= 1'b0;
        r_stop_idx <= 1'b0;
      end else begin
        if (rx_bd_en) begin
          r_cnt <= r_cnt + 4'd1;
        end
        if (w_shift) begin
          r_bit   <= r_bit + 3'd1;
          r_shift <= {w_rxs, r_shift[7:1]};
        end
        if (w_par_smp) begin
          r_perr_acc <= c_par_odd ? ~(^r_shift ^ w_rxs) : (^r_shift ^ w_rxs);
        end
        if (w_stop_smp) begin
          r_stop_idx <= ~r_stop_idx;
          if (!w_rxs) begin
            r_ferr_acc <= 1'b1;
          end
        end
      end
    end
  end

`ifdef UART_RX_OVERRUN_EN
  logic r_ovr;
  logic w_keep_old;

  // Unacknowledged byte still held: new frame is dropped
  assign w_keep_old = r_rdy && !rx_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 1'b0;
    end else if (w_load) begin
      r_ovr <= w_keep_old;
    end else if (r_rdy && rx_ack) begin
      r_ovr <= 1'b0;
    end
  end

  assign rx_ovr = r_ovr;
`else
  logic w_keep_old;

  assign w_keep_old = 1'b0;
  assign rx_ovr     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy  <= 1'b0;
      r_data <= 8'h00;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else if (w_load) begin
      r_rdy <= 1'b1;
      if (!w_keep_old) begin
        r_data <= r_shift;
        r_perr <= r_perr_acc;
        r_ferr <= r_ferr_acc;
      end
    end else if (r_rdy && rx_ack) begin
      r_rdy <= 1'b0;
    end
  end

  assign rx_rdy  = r_rdy;
  assign rx_data = r_data;
  assign rx_perr = r_perr;
  assign rx_ferr = r_ferr;

endmodule
`default_nettype wire
